// File: rtl/branch_pkg.sv
// Shared definitions for the branch redirect controller: FSM encoding and
// instruction-stream constants.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SETTLE   = 2'd2
    } state_t;

    localparam int unsigned INSTR_BYTES = 4;

    // Wide enough for FETCH_LAT up to 7.
    localparam int unsigned CNT_W = 3;

    // Clears bit 0 of a JALR target; truncated to XLEN at the point of use.
    localparam logic [63:0] JALR_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFE;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect address generation: taken target (PC- or rs1-relative,
// JALR bit 0 cleared) and sequential fall-through. All sums wrap mod 2^XLEN.
module branch_target_calc
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_jalr,
    output logic [XLEN-1:0] target_c,
    output logic [XLEN-1:0] fallthrough_c
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] target_sum;

    always_comb begin
        base          = is_jalr ? rs1 : pc;
        target_sum    = base + imm;
        target_c      = is_jalr ? (target_sum & XLEN'(JALR_ALIGN_MASK)) : target_sum;
        fallthrough_c = pc + XLEN'(INSTR_BYTES);
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Post-EX redirect sequencer: detects mispredicts, flushes IF/ID and ID/EX,
// holds a redirect to fetch until accepted, then masks stale fetch output.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FETCH_LAT = 1
`ifdef BRANCH_STATS_EN
    ,
    parameter int unsigned STAT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_is_jalr,
    input  logic              ex_branch_taken,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_imm,
    input  logic [XLEN-1:0]   ex_rs1,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              redirect_ready,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              ex_stall,
`ifdef BRANCH_STATS_EN
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts,
`endif
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = (FETCH_LAT == 0) ? '0 : CNT_W'(FETCH_LAT - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [XLEN-1:0]   pc_next;
    logic              redirect_valid_next;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   fallthrough;
    logic              is_ctrl;
    logic              act_taken;
    logic              resolve;
    logic              mispredict;

    branch_target_calc #(
        .XLEN (XLEN)
    ) u_target (
        .pc            (ex_pc),
        .imm           (ex_imm),
        .rs1           (ex_rs1),
        .is_jalr       (ex_is_jalr),
        .target_c      (target),
        .fallthrough_c (fallthrough)
    );

    // Resolution: a jump is always taken and overrides the branch flag.
    always_comb begin
        is_ctrl    = ex_is_branch | ex_is_jump;
        act_taken  = ex_is_jump | (ex_is_branch & ex_branch_taken);
        resolve    = ex_valid & is_ctrl & (state == IDLE);
        mispredict = resolve & (act_taken != ex_pred_taken);
    end

    // Next-state and control outputs; flush/stall/busy are forced low during reset.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pc_next     = redirect_pc;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        ex_stall    = 1'b0;
        busy        = 1'b0;

        unique case (state)
            IDLE: begin
                if (mispredict) begin
                    state_next  = REDIRECT;
                    pc_next     = act_taken ? target : fallthrough;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            REDIRECT: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                ex_stall    = 1'b1;
                busy        = 1'b1;
                if (redirect_ready) begin
                    state_next = (FETCH_LAT == 0) ? IDLE : SETTLE;
                    cnt_next   = CNT_INIT;
                end
            end
            SETTLE: begin
                flush_if_id = 1'b1;
                ex_stall    = 1'b1;
                busy        = 1'b1;
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (rst) begin
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
            ex_stall    = 1'b0;
            busy        = 1'b0;
        end

        redirect_valid_next = (state_next == REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            redirect_pc    <= '0;
            redirect_valid <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            redirect_pc    <= pc_next;
            redirect_valid <= redirect_valid_next;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_branches_next;
    logic [STAT_W-1:0] stat_mispredicts_next;

    // Saturating event counters.
    always_comb begin
        stat_branches_next    = stat_branches;
        stat_mispredicts_next = stat_mispredicts;
        if (resolve && (stat_branches != '1)) begin
            stat_branches_next = stat_branches + STAT_W'(1);
        end
        if (mispredict && (stat_mispredicts != '1)) begin
            stat_mispredicts_next = stat_mispredicts + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= stat_branches_next;
            stat_mispredicts <= stat_mispredicts_next;
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: a transaction-level reference
// model compared every cycle plus directed vectors with literal expectations.
module tb_branch_redirect_ctrl;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned FETCH_LAT = 2;
    localparam int unsigned STAT_W    = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ex_valid, ex_is_branch, ex_is_jump, ex_is_jalr;
    logic            ex_branch_taken, ex_pred_taken;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready = 1'b0;
    logic            flush_if_id, flush_id_ex, ex_stall, busy;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_redirect_ctrl #(
        .XLEN      (XLEN),
        .FETCH_LAT (FETCH_LAT)
`ifdef BRANCH_STATS_EN
        ,
        .STAT_W    (STAT_W)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_is_jalr       (ex_is_jalr),
        .ex_branch_taken  (ex_branch_taken),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_rs1           (ex_rs1),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .ex_stall         (ex_stall),
`ifdef BRANCH_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .busy             (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding request, its address, and remaining stale-fetch cycles.
    bit          m_pend   = 1'b0;
    logic [31:0] m_pc     = 32'h0;
    int          m_settle = 0;
    int          m_br     = 0;
    int          m_mis    = 0;

    function automatic bit m_taken();
        return ex_is_jump || (ex_is_branch && ex_branch_taken);
    endfunction

    function automatic logic [31:0] m_dest();
        if (!m_taken())    return ex_pc + 32'd4;
        if (ex_is_jalr)    return (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
        return ex_pc + ex_imm;
    endfunction

    function automatic bit m_wrong();
        return ex_valid && (ex_is_branch || ex_is_jump) && (m_taken() != ex_pred_taken);
    endfunction

    function automatic bit m_idle();
        return !m_pend && (m_settle == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 1'b0; m_pc = 32'h0; m_settle = 0; m_br = 0; m_mis = 0;
        end else if (m_pend) begin
            if (redirect_ready) begin
                m_pend   = 1'b0;
                m_settle = FETCH_LAT;
            end
        end else if (m_settle > 0) begin
            m_settle--;
        end else if (ex_valid && (ex_is_branch || ex_is_jump)) begin
            m_br++;
            if (m_wrong()) begin
                m_pend = 1'b1;
                m_pc   = m_dest();
                m_mis++;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    function automatic logic [STAT_W-1:0] m_sat(input int n);
        return (n >= (1 << STAT_W) - 1) ? '1 : STAT_W'(n);
    endfunction
`endif

    // Every-cycle compare against the model, half a period after the edge.
    always @(negedge clk) begin
        bit mp;
        bit active;
        mp     = !rst && m_idle() && m_wrong();
        active = !rst && !m_idle();
        check1 ("model_redirect_valid", redirect_valid, m_pend);
        check32("model_redirect_pc",    redirect_pc,    m_pc);
        check1 ("model_flush_if_id",    flush_if_id,    active || mp);
        check1 ("model_flush_id_ex",    flush_id_ex,    (!rst && m_pend) || mp);
        check1 ("model_ex_stall",       ex_stall,       active);
        check1 ("model_busy",           busy,           active);
`ifdef BRANCH_STATS_EN
        check32("model_stat_branches",    32'(stat_branches),    32'(m_sat(m_br)));
        check32("model_stat_mispredicts", 32'(stat_mispredicts), 32'(m_sat(m_mis)));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input bit b, input bit j, input bit jr, input bit t,
                          input bit p, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1);
        ex_valid = v; ex_is_branch = b; ex_is_jump = j; ex_is_jalr = jr;
        ex_branch_taken = t; ex_pred_taken = p; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    endtask

    task automatic clr_ex();
        set_ex(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    // Called in the mispredict cycle with EX inputs applied; walks the full redirect.
    task automatic run_redirect(input string name, input logic [31:0] exp_pc,
                                input int hold, input bit noise);
        int n;
        #1;
        check1({name, "_flush_if_id_N"}, flush_if_id, 1'b1);
        check1({name, "_flush_id_ex_N"}, flush_id_ex, 1'b1);
        check1({name, "_rv_low_N"},      redirect_valid, 1'b0);
        @(posedge clk); #1;
        clr_ex();
        check1 ({name, "_rv_N1"}, redirect_valid, 1'b1);
        check32({name, "_pc_N1"}, redirect_pc, exp_pc);
        for (int i = 0; i < hold; i++) begin
            if (noise) set_ex(1, 1, 0, 0, 1, 0, 32'h900 + 32'(i * 4), 32'h40, 32'h0);
            cyc();
            check1 ({name, "_rv_hold"}, redirect_valid, 1'b1);
            check32({name, "_pc_hold"}, redirect_pc, exp_pc);
        end
        clr_ex();
        redirect_ready = 1'b1;
        cyc();
        redirect_ready = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            cyc();
        end
        check32({name, "_settle_cycles"}, 32'(n), 32'(FETCH_LAT));
    endtask

    initial begin
        clr_ex();
        repeat (3) begin
            cyc();
            check1("rst_busy",  busy,        1'b0);
            check1("rst_flush", flush_if_id, 1'b0);
        end
        rst = 1'b0;
        cyc();
        check1 ("post_rst_rv", redirect_valid, 1'b0);
        check32("post_rst_pc", redirect_pc,    32'h0);

        set_ex(1, 1, 0, 0, 1, 0, 32'h100, 32'h20, 32'h0);
        run_redirect("t1_taken", 32'h120, 0, 0);

        set_ex(1, 1, 0, 0, 0, 1, 32'h200, 32'h40, 32'h0);
        run_redirect("t2_not_taken", 32'h204, 2, 0);

        set_ex(1, 1, 0, 0, 1, 1, 32'h300, 32'h10, 32'h0);
        #1 check1("t2_correct_no_flush", flush_if_id, 1'b0);
        cyc();
        check1("t2_correct_no_rv", redirect_valid, 1'b0);
        set_ex(1, 0, 0, 0, 1, 0, 32'h304, 32'h10, 32'h0);
        redirect_ready = 1'b1;
        cyc();
        redirect_ready = 1'b0;
        check1("noncontrol_no_busy", busy, 1'b0);

        set_ex(1, 0, 1, 1, 0, 0, 32'h400, 32'h4, 32'h1001);
        run_redirect("t3_jalr", 32'h1004, 1, 0);
        set_ex(1, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h20, 32'h0);
        run_redirect("t3_jal_wrap", 32'h10, 0, 0);
        set_ex(1, 1, 1, 0, 0, 1, 32'h480, 32'h8, 32'h0);
        #1 check1("t3_jump_wins_no_flush", flush_id_ex, 1'b0);
        cyc();
        set_ex(1, 1, 0, 0, 1, 0, 32'h1000, 32'hFFFF_FFF0, 32'h0);
        run_redirect("t3_neg_imm", 32'hFF0, 0, 0);

        set_ex(1, 1, 0, 0, 1, 0, 32'h500, 32'h8, 32'h0);
        run_redirect("t4_hold", 32'h508, 5, 1);

        set_ex(1, 1, 0, 0, 1, 0, 32'h600, 32'h10, 32'h0);
        cyc();
        clr_ex();
        check1("t5_rv_before_rst", redirect_valid, 1'b1);
        rst = 1'b1;
        #1;
        check1("t5_rst_stall", ex_stall,    1'b0);
        check1("t5_rst_flush", flush_id_ex, 1'b0);
        check1("t5_rst_busy",  busy,        1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check1 ("t5_rv_after",   redirect_valid, 1'b0);
        check1 ("t5_busy_after", busy,           1'b0);
        check32("t5_pc_after",   redirect_pc,    32'h0);
        set_ex(1, 1, 0, 0, 0, 1, 32'h700, 32'h10, 32'h0);
        run_redirect("t5_recover", 32'h704, 1, 0);

`ifdef BRANCH_STATS_EN
        for (int k = 0; k < 20; k++) begin
            set_ex(1, 1, 0, 0, 1, 0, 32'h800, 32'h4, 32'h0);
            run_redirect("t6_stats", 32'h804, 0, 0);
        end
        check32("t6_branches_sat",    32'(stat_branches),    32'hF);
        check32("t6_mispredicts_sat", 32'(stat_mispredicts), 32'hF);
`endif

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
